// File: rtl/uart_tx_rr_scheduler_if.sv
// uart_tx_rr_scheduler_if: requester-side and UART-TX-side signals of the round-robin TX scheduler
interface uart_tx_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int W_OUT   = 24
);
  localparam int GW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][W_OUT-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          m_valid;
  logic [W_OUT-1:0]              m_data;
  logic                          m_ready;
  logic [GW-1:0]                 grant_id;
  logic                          busy;
  logic [NUM_REQ-1:0]            done;
  modport master (
    input  req_valid, req_data, m_ready,
    output req_ready, m_valid, m_data, grant_id, busy, done
  );
  modport slave (
    output req_valid, req_data, m_ready,
    input  req_ready, m_valid, m_data, grant_id, busy, done
  );
endinterface

// File: rtl/uart_tx_rr_scheduler.sv
// uart_tx_rr_scheduler: round-robin sharing of one multi-word UART TX among NUM_REQ requesters
module uart_tx_rr_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT         = 24,
  parameter int IFG_CLKS      = 0
) (
  input logic                    clk,
  input logic                    rstn,
  uart_tx_rr_scheduler_if.master bus
);
  localparam int GW        = $clog2(NUM_REQ);
  localparam int CW        = IFG_CLKS > 1 ? $clog2(IFG_CLKS) : 1;
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  if (NUM_WORDS * BITS_PER_WORD != W_OUT) begin : g_bad_width
    $error("W_OUT must be a multiple of BITS_PER_WORD");
  end
  typedef enum logic [1:0] {IDLE, OFFER, DRAIN, GAP} state_t;
  state_t         state, state_n;
  logic [GW-1:0]  ptr, sel;
  logic [GW:0]    idx;
  logic           found;
  logic [CW-1:0]  gap_cnt;
  logic           drain_exit;
  // Scan from the highest offset down so the requester nearest ptr wins.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (GW+1)'(k);
      idx = idx >= (GW+1)'(NUM_REQ) ? idx - (GW+1)'(NUM_REQ) : idx;
      if (bus.req_valid[idx[GW-1:0]]) begin
        sel   = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end
  assign drain_exit = state == DRAIN && bus.m_ready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = found ? OFFER : IDLE;
      OFFER:   state_n = bus.m_ready ? DRAIN : OFFER;
      DRAIN:   state_n = bus.m_ready ? (IFG_CLKS > 0 ? GAP : IDLE) : DRAIN;
      GAP:     state_n = gap_cnt == '0 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  assign bus.m_valid   = state == OFFER;
  assign bus.busy      = state != IDLE;
  assign bus.req_ready = (state == IDLE && found) ? NUM_REQ'(1) << sel : '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      ptr          <= '0;
      bus.m_data   <= '0;
      bus.grant_id <= '0;
      bus.done     <= '0;
      gap_cnt      <= '0;
    end else begin
      state    <= state_n;
      bus.done <= drain_exit ? NUM_REQ'(1) << bus.grant_id : '0;
      gap_cnt  <= drain_exit ? (IFG_CLKS > 0 ? CW'(IFG_CLKS - 1) : '0)
                : (state == GAP && gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
      if (state == IDLE && found) begin
        bus.m_data   <= bus.req_data[sel];
        bus.grant_id <= sel;
        ptr          <= sel == GW'(NUM_REQ - 1) ? '0 : sel + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_rr_scheduler.sv
// tb_uart_tx_rr_scheduler: directed scoreboard bench for the round-robin UART TX scheduler
module tb_uart_tx_rr_scheduler;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic stall = 1'b0;
  logic [2:0] tx_cnt = '0;
  logic [2:0] gtx_cnt = '0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {logic [1:0] g; logic [23:0] d;} exp_t;
  exp_t exp_q[$];
  logic [1:0] exp_done[$];

  always #5 clk = ~clk;

  uart_tx_rr_scheduler_if #(.NUM_REQ(4), .W_OUT(24)) b ();
  uart_tx_rr_scheduler_if #(.NUM_REQ(4), .W_OUT(24)) bg ();

  uart_tx_rr_scheduler #(.NUM_REQ(4), .BITS_PER_WORD(8), .W_OUT(24), .IFG_CLKS(0))
    dut (.clk(clk), .rstn(rstn), .bus(b));
  uart_tx_rr_scheduler #(.NUM_REQ(4), .BITS_PER_WORD(8), .W_OUT(24), .IFG_CLKS(3))
    dut_g (.clk(clk), .rstn(rstn), .bus(bg));

  // TX models: busy for 4 cycles after each accepted message
  assign b.m_ready  = tx_cnt == '0 && !stall;
  assign bg.m_ready = gtx_cnt == '0;
  always @(posedge clk) begin
    tx_cnt  <= (b.m_valid && b.m_ready) ? 3'd4 : (tx_cnt != '0 ? tx_cnt - 3'd1 : tx_cnt);
    gtx_cnt <= (bg.m_valid && bg.m_ready) ? 3'd4 : (gtx_cnt != '0 ? gtx_cnt - 3'd1 : gtx_cnt);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (rstn) begin
      if (b.m_valid && b.m_ready) begin
        if (exp_q.size() == 0) fail("handshake_unexpected");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("grant_id", 32'(b.grant_id), 32'(e.g));
          check("m_data", 32'(b.m_data), 32'(e.d));
          exp_done.push_back(e.g);
        end
      end
      if (b.done != '0) begin
        if (exp_done.size() == 0) fail("done_unexpected");
        else begin
          logic [1:0] g;
          g = exp_done.pop_front();
          check("done", 32'(b.done), 32'(4'b0001 << g));
        end
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rstn = 1'b0;
    b.req_valid = '0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_done.delete();
    rstn = 1'b1;
  endtask

  task automatic issue(input logic [3:0] mask, input int n, input bit hold);
    logic [3:0] pend;
    int cnt;
    int t;
    pend = mask;
    cnt = 0;
    t = 0;
    while (cnt < n && t < 500) begin
      @(negedge clk);
      b.req_valid = hold ? mask : pend;
      #1;
      if (b.req_ready != '0) begin
        check("req_ready_onehot", 32'($onehot(b.req_ready)), 32'd1);
        pend &= ~b.req_ready;
        cnt++;
      end
      t++;
    end
    if (cnt < n) fail("issue_timeout");
    @(negedge clk);
    b.req_valid = '0;
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while ((b.busy || exp_q.size() != 0 || exp_done.size() != 0) && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 300) fail("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    int n;
    logic [23:0] d [4];
    d[0] = 24'h0A0B0C; d[1] = 24'h1A1B1C; d[2] = 24'h2A2B2C; d[3] = 24'h3A3B3C;
    b.req_valid = '0;
    b.req_data = '0;
    bg.req_valid = '0;
    bg.req_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", 32'(b.m_valid), 32'd0);
    check("rst_busy", 32'(b.busy), 32'd0);
    check("rst_grant_id", 32'(b.grant_id), 32'd0);
    check("rst_done", 32'(b.done), 32'd0);
    check("rst_m_data", 32'(b.m_data), 32'd0);

    // single request, TX idle
    @(negedge clk);
    rstn = 1'b1;
    b.req_data[0] = 24'h3C5AA5;
    b.req_valid = 4'b0001;
    exp_q.push_back('{2'd0, 24'h3C5AA5});
    #1;
    check("t1_req_ready", 32'(b.req_ready), 32'h1);
    @(negedge clk);
    b.req_valid = '0;
    #1;
    check("t1_m_valid", 32'(b.m_valid), 32'd1);
    check("t1_m_data", 32'(b.m_data), 32'h3C5AA5);
    check("t1_busy", 32'(b.busy), 32'd1);
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!b.m_ready && t < 50);
    if (t >= 50) fail("t1_drain_timeout");
    check("t1_done_not_early", 32'(b.done), 32'd0);
    @(negedge clk);
    #1;
    check("t1_done_pulse", 32'(b.done), 32'h1);
    @(negedge clk);
    #1;
    check("t1_done_clear", 32'(b.done), 32'h0);
    wait_idle();
    for (int i = 0; i < 4; i++) b.req_data[i] = d[i];

    // all four held high: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back('{2'(i % 4), d[i % 4]});
    issue(4'b1111, 5, 1'b1);
    wait_idle();

    // ptr=2 after serving 1; requesters 0 and 3 -> 3 first
    do_reset();
    exp_q.push_back('{2'd1, d[1]});
    issue(4'b0010, 1, 1'b0);
    wait_idle();
    exp_q.push_back('{2'd3, d[3]});
    exp_q.push_back('{2'd0, d[0]});
    issue(4'b1001, 2, 1'b0);
    wait_idle();

    // TX not ready for 10 cycles while offering
    do_reset();
    stall = 1'b1;
    b.req_valid = 4'b0100;
    exp_q.push_back('{2'd2, d[2]});
    #1;
    check("t4_req_ready", 32'(b.req_ready), 32'h4);
    @(negedge clk);
    b.req_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_m_valid", 32'(b.m_valid), 32'd1);
      check("t4_m_data", 32'(b.m_data), 32'(d[2]));
      check("t4_req_ready_low", 32'(b.req_ready), 32'd0);
      @(negedge clk);
    end
    exp_q.push_back('{2'd1, d[1]});
    stall = 1'b0;
    issue(4'b0010, 1, 1'b0);
    wait_idle();

    // reset while draining: no done, ptr back to 0
    do_reset();
    exp_q.push_back('{2'd2, d[2]});
    b.req_valid = 4'b0100;
    t = 0;
    do begin
      @(negedge clk);
      b.req_valid = b.busy ? 4'b0000 : 4'b0100;
      #1;
      t++;
    end while (!(b.m_valid && b.m_ready) && t < 50);
    if (t >= 50) fail("t6_handshake_timeout");
    @(negedge clk);
    #1;
    check("t6_in_drain", 32'(b.busy && !b.m_valid), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check("t6_m_valid", 32'(b.m_valid), 32'd0);
    check("t6_busy", 32'(b.busy), 32'd0);
    check("t6_grant_id", 32'(b.grant_id), 32'd0);
    check("t6_done", 32'(b.done), 32'd0);
    exp_q.delete();
    exp_done.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("t6_no_done", 32'(b.done), 32'd0);
    end
    exp_q.push_back('{2'd0, d[0]});
    exp_q.push_back('{2'd3, d[3]});
    issue(4'b1001, 2, 1'b0);
    wait_idle();

    // inter-frame gap of 3 clocks on the IFG_CLKS=3 instance
    do_reset();
    for (int i = 0; i < 4; i++) bg.req_data[i] = d[i];
    bg.req_valid = 4'b0011;
    for (int r = 0; r < 2; r++) begin
      t = 0;
      do begin
        @(negedge clk);
        #1;
        t++;
      end while (bg.done == '0 && t < 100);
      if (t >= 100) fail("t5_done_timeout");
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (bg.req_ready == '0 && n < 50);
      check("t5_gap_cycles", 32'(n), 32'd3);
    end
    @(negedge clk);
    bg.req_valid = '0;
    repeat (20) @(negedge clk);

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_exp_done_empty", 32'(exp_done.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
